// File: rtl/vec_cmd_enq_queues.sv
// vec_cmd_enq_queues: atomic dual-queue enqueue stage (cmdq + ximm1q) behind the vector decoder
//   vec_cmd_enq_fifo   : single-clock FIFO, any depth >= 2, registered count, no bypass
//     enq/enq_bits     : write at tail (caller guarantees not full)
//     deq_*            : valid/ready head, combinational read of storage
//     count/ready      : occupancy and not-full from the registered count
//   vec_cmd_enq_queues : decoder strobes in, replay/fire and ready masks out, two drain ports
module vec_cmd_enq_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq,
    input  logic [W-1:0]           enq_bits,
    input  logic                   deq_ready,
    output logic                   deq_valid,
    output logic [W-1:0]           deq_bits,
    output logic                   ready,
    output logic [$clog2(D+1)-1:0] count
);
    localparam int PW = $clog2(D);
    localparam int CW = $clog2(D+1);
    localparam logic [PW-1:0] LAST = PW'(D - 1);
    localparam logic [CW-1:0] FULL = CW'(D);
    logic [W-1:0] mem [D];
    logic [PW-1:0] head, tail;
    logic pop;
    always_comb begin
        pop       = deq_ready & deq_valid;
        deq_valid = count != '0;
        ready     = count != FULL;
        deq_bits  = mem[head];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail == LAST ? '0 : tail + 1'b1;
            if (pop) head <= head == LAST ? '0 : head + 1'b1;
            count <= count + CW'(enq) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (enq) mem[tail] <= enq_bits;
    end
endmodule

module vec_cmd_enq_queues #(
    parameter int CMD_W       = 20,
    parameter int IMM_W       = 64,
    parameter int CMDQ_DEPTH  = 4,
    parameter int XIMMQ_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             io_valid,
    input  logic                             io_sigs_enq_cmdq,
    input  logic                             io_sigs_enq_ximm1q,
    input  logic [CMD_W-1:0]                 io_cmd_bits,
    input  logic [IMM_W-1:0]                 io_imm_bits,
    output logic                             io_replay,
    output logic                             io_fire,
    output logic                             io_mask_cmdq_ready,
    output logic                             io_mask_ximm1q_ready,
    output logic                             io_cmdq_deq_valid,
    input  logic                             io_cmdq_deq_ready,
    output logic [CMD_W-1:0]                 io_cmdq_deq_bits,
    output logic                             io_ximm1q_deq_valid,
    input  logic                             io_ximm1q_deq_ready,
    output logic [IMM_W-1:0]                 io_ximm1q_deq_bits,
    output logic [$clog2(CMDQ_DEPTH+1)-1:0]  io_cmdq_count,
    output logic [$clog2(XIMMQ_DEPTH+1)-1:0] io_ximm1q_count
);
    // a full queue stalls the whole instruction, so neither queue writes on replay
    assign io_replay = io_valid & ((io_sigs_enq_cmdq & ~io_mask_cmdq_ready) |
                                   (io_sigs_enq_ximm1q & ~io_mask_ximm1q_ready));
    assign io_fire   = io_valid & ~io_replay;

    vec_cmd_enq_fifo #(.W(CMD_W), .D(CMDQ_DEPTH)) cmdq (
        .clk       (clk),
        .reset     (reset),
        .enq       (io_fire & io_sigs_enq_cmdq),
        .enq_bits  (io_cmd_bits),
        .deq_ready (io_cmdq_deq_ready),
        .deq_valid (io_cmdq_deq_valid),
        .deq_bits  (io_cmdq_deq_bits),
        .ready     (io_mask_cmdq_ready),
        .count     (io_cmdq_count)
    );

    vec_cmd_enq_fifo #(.W(IMM_W), .D(XIMMQ_DEPTH)) ximm1q (
        .clk       (clk),
        .reset     (reset),
        .enq       (io_fire & io_sigs_enq_ximm1q),
        .enq_bits  (io_imm_bits),
        .deq_ready (io_ximm1q_deq_ready),
        .deq_valid (io_ximm1q_deq_valid),
        .deq_bits  (io_ximm1q_deq_bits),
        .ready     (io_mask_ximm1q_ready),
        .count     (io_ximm1q_count)
    );
endmodule
